// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// The ovf signal exists only when ADDER_OVF_EN is defined.
interface pipelined_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef ADDER_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder: STAGES chunk adders, one register per stage, valid/ready on both sides.
// Define ADDER_OVF_EN to add the signed-overflow output (ovf) and its sign-bit pipeline.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    pipelined_adder_if.slave bus
);
    localparam int CHUNK = WIDTH / STAGES;

    if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipelined_adder: WIDTH must be a positive multiple of STAGES");
    end

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] v_in;
    logic [STAGES-1:0] load;

    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  s_q   [STAGES];
    logic [STAGES-1:0] c_q;

    logic [WIDTH-1:0]  a_in  [STAGES];
    logic [WIDTH-1:0]  b_in  [STAGES];
    logic [WIDTH-1:0]  s_in  [STAGES];
    logic [STAGES-1:0] c_in;
    logic [WIDTH-1:0]  s_nxt [STAGES];
    logic [CHUNK:0]    part  [STAGES];

    // A stage loads when it is empty or its successor loads, so holes close up behind a stall.
    always_comb begin
        logic downstream;
        downstream = bus.out_ready;
        load       = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            downstream = !v[k] || downstream;
            load[k]    = downstream;
        end
    end

    always_comb begin
        a_in[0] = bus.a;
        b_in[0] = bus.b;
        s_in[0] = '0;
        c_in[0] = bus.cin;
        v_in[0] = bus.in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            s_in[k] = s_q[k-1];
            c_in[k] = c_q[k-1];
            v_in[k] = v[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            part[k] = {1'b0, a_in[k][k*CHUNK +: CHUNK]}
                    + {1'b0, b_in[k][k*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, c_in[k]};
            s_nxt[k] = s_in[k];
            s_nxt[k][k*CHUNK +: CHUNK] = part[k][CHUNK-1:0];
        end
    end

    // Data registers only move when their stage loads real data; a stalled stage holds its result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v   <= '0;
            c_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    v[k] <= v_in[k];
                    if (v_in[k]) begin
                        a_q[k] <= a_in[k];
                        b_q[k] <= b_in[k];
                        s_q[k] <= s_nxt[k];
                        c_q[k] <= part[k][CHUNK];
                    end
                end
            end
        end
    end

    // Already-consumed operand chunks are never read downstream and are trimmed by synthesis.
    logic unused_ops;
    always_comb begin
        unused_ops = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            unused_ops = unused_ops ^ (^a_q[k]) ^ (^b_q[k]);
        end
    end

`ifdef ADDER_OVF_EN
    logic ovf_q;
    logic ovf_nxt;

    assign ovf_nxt = (a_in[STAGES-1][WIDTH-1] == b_in[STAGES-1][WIDTH-1])
                  && (s_nxt[STAGES-1][WIDTH-1] != a_in[STAGES-1][WIDTH-1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (load[STAGES-1] && v_in[STAGES-1]) begin
            ovf_q <= ovf_nxt;
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.in_ready  = load[0];
    assign bus.out_valid = v[STAGES-1];
    assign bus.sum       = s_q[STAGES-1];
    assign bus.cout      = c_q[STAGES-1];

endmodule
